// File: rtl/j11bus_ctl.sv
// j11bus_ctl: DCJ11 bus bridge with one-outstanding memory requests, ack timeout, GP powerup word and control register file.
// Optional line-time clock divider enabled by defining J11BUS_LTC_EN.
module j11bus_ctl #(
    parameter int AW = 22,
    parameter int DW = 16,
    parameter int TIMEOUT = 1023,
    parameter logic [DW-1:0] PWRUP_RST = DW'(16'o000005)
`ifdef J11BUS_LTC_EN
    , parameter int LTC_DIV = 833333
`endif
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          busreq,
    input  logic          buswr,
    input  logic          busgp,
    input  logic [AW-1:0] busaddr,
    input  logic [DW-1:0] buswdata,
    output logic          busack,
    output logic [DW-1:0] busrdata,
    output logic          buserr,
    output logic          memreq,
    output logic          memwr,
    output logic [AW-1:0] memaddr,
    output logic [DW-1:0] memwdata,
    input  logic          memack,
    input  logic [DW-1:0] memrdata,
    output logic          j11init,
    output logic          j11halt,
    output logic          j11parity,
    output logic          j11event,
    output logic          j11pwrf,
    output logic          j11fpe,
    output logic [3:0]    j11irq,
    input  logic          regreq,
    input  logic          regwr,
    input  logic [1:0]    regaddr,
    input  logic [31:0]   regwdata,
    output logic          regack,
    output logic [31:0]   regrdata
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MEMWAIT = 1'b1;
    localparam int CW = $clog2(TIMEOUT);
`ifdef J11BUS_LTC_EN
    localparam logic [12:0] CTRL_MASK = 13'h1F3F;
`else
    localparam logic [12:0] CTRL_MASK = 13'h0F3F;
`endif

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_tocnt;
    logic [7:0]    r_gp;
    logic          r_ovr;
    logic [12:0]   r_ctrl;
    logic [DW-1:0] r_pwrup;
    logic          w_tmo;
    logic          w_ovr;
    logic          w_clr;
    logic          w_tick;
    logic [31:0]   w_rd;

    assign w_tmo = r_state == MEMWAIT && !memack && r_cnt == CW'(TIMEOUT - 1);
    assign w_ovr = r_state == MEMWAIT && busreq;
    assign w_clr = regreq && regwr && regaddr == 2'd3 && regwdata[0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_gp     <= '0;
            busack   <= 1'b0;
            buserr   <= 1'b0;
            busrdata <= '0;
            memreq   <= 1'b0;
            memwr    <= 1'b0;
            memaddr  <= '0;
            memwdata <= '0;
        end else begin
            busack <= 1'b0;
            memreq <= 1'b0;
            if (r_state == IDLE) begin
                if (busreq && busgp) begin
                    busack   <= 1'b1;
                    buserr   <= 1'b0;
                    r_gp     <= busaddr[7:0];
                    busrdata <= (buswr && busaddr[7:0] == 8'o0) ? r_pwrup : '0;
                end else if (busreq) begin
                    memreq   <= 1'b1;
                    memwr    <= buswr;
                    memaddr  <= busaddr;
                    memwdata <= buswdata;
                    r_cnt    <= '0;
                    r_state  <= MEMWAIT;
                end
            end else if (memack || w_tmo) begin
                // memack takes priority over a coincident timeout expiry
                busack   <= 1'b1;
                buserr   <= !memack;
                busrdata <= memack ? memrdata : '0;
                r_state  <= IDLE;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_rd = regaddr == 2'd0 ? 32'(r_ctrl) :
               regaddr == 2'd1 ? 32'(r_pwrup) :
               regaddr == 2'd2 ? {5'b0, r_ctrl[12], r_state == MEMWAIT, r_ovr, r_gp, r_tocnt} : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            regack   <= 1'b0;
            regrdata <= '0;
            r_ctrl   <= 13'h0F3E;
            r_pwrup  <= PWRUP_RST;
            r_tocnt  <= '0;
            r_ovr    <= 1'b0;
        end else begin
            regack   <= regreq;
            regrdata <= (regreq && !regwr) ? w_rd : '0;
            if (regreq && regwr && regaddr == 2'd0) r_ctrl <= regwdata[12:0] & CTRL_MASK;
            if (regreq && regwr && regaddr == 2'd1) r_pwrup <= regwdata[DW-1:0];
            r_tocnt <= w_clr ? '0 : (w_tmo && r_tocnt != 16'hFFFF) ? r_tocnt + 1'b1 : r_tocnt;
            r_ovr   <= w_clr ? 1'b0 : (r_ovr || w_ovr);
        end
    end

`ifdef J11BUS_LTC_EN
    localparam int DVW = $clog2(LTC_DIV);
    logic [DVW-1:0] r_div;
    assign w_tick = r_ctrl[12] && r_div == DVW'(LTC_DIV - 1);
    always_ff @(posedge clk) begin
        if (!rstn || !r_ctrl[12] || w_tick) r_div <= '0;
        else r_div <= r_div + 1'b1;
    end
`else
    assign w_tick = 1'b0;
`endif

    assign j11init   = r_ctrl[0];
    assign j11halt   = r_ctrl[1];
    assign j11parity = r_ctrl[2];
    assign j11event  = r_ctrl[3] && !w_tick;
    assign j11pwrf   = r_ctrl[4];
    assign j11fpe    = r_ctrl[5];
    assign j11irq    = r_ctrl[11:8];
endmodule

// File: tb/tb_j11bus_ctl.sv
// tb_j11bus_ctl: directed self-checking bench for j11bus_ctl (TIMEOUT=16; LTC_DIV=10 when J11BUS_LTC_EN).
module tb_j11bus_ctl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        busreq = 1'b0, buswr = 1'b0, busgp = 1'b0;
    logic [21:0] busaddr = '0;
    logic [15:0] buswdata = '0;
    logic        busack, buserr;
    logic [15:0] busrdata;
    logic        memreq, memwr;
    logic [21:0] memaddr;
    logic [15:0] memwdata;
    logic        memack = 1'b0;
    logic [15:0] memrdata = '0;
    logic        j11init, j11halt, j11parity, j11event, j11pwrf, j11fpe;
    logic [3:0]  j11irq;
    logic        regreq = 1'b0, regwr = 1'b0;
    logic [1:0]  regaddr = '0;
    logic [31:0] regwdata = '0;
    logic        regack;
    logic [31:0] regrdata;
    int total = 0, bad = 0, n_mreq = 0;

    always #5 clk = ~clk;
    always @(posedge clk) if (memreq) n_mreq++;

    j11bus_ctl #(.TIMEOUT(16)
`ifdef J11BUS_LTC_EN
        , .LTC_DIV(10)
`endif
    ) dut (
        .clk(clk), .rstn(rstn), .busreq(busreq), .buswr(buswr), .busgp(busgp),
        .busaddr(busaddr), .buswdata(buswdata), .busack(busack), .busrdata(busrdata),
        .buserr(buserr), .memreq(memreq), .memwr(memwr), .memaddr(memaddr),
        .memwdata(memwdata), .memack(memack), .memrdata(memrdata), .j11init(j11init),
        .j11halt(j11halt), .j11parity(j11parity), .j11event(j11event), .j11pwrf(j11pwrf),
        .j11fpe(j11fpe), .j11irq(j11irq), .regreq(regreq), .regwr(regwr), .regaddr(regaddr),
        .regwdata(regwdata), .regack(regack), .regrdata(regrdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        regreq = 1'b1; regwr = 1'b0; regaddr = a;
        tick();
        regreq = 1'b0;
        chk({tag, "_ack"}, {31'b0, regack}, 32'd1);
        chk(tag, regrdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        regreq = 1'b1; regwr = 1'b1; regaddr = a; regwdata = d;
        tick();
        regreq = 1'b0; regwr = 1'b0;
    endtask

    task automatic gp(input logic w, input logic [7:0] code, input logic [15:0] exp, input string tag);
        busreq = 1'b1; busgp = 1'b1; buswr = w; busaddr = {14'b0, code};
        tick();
        busreq = 1'b0; busgp = 1'b0;
        chk({tag, "_ack"}, {31'b0, busack}, 32'd1);
        chk({tag, "_err"}, {31'b0, buserr}, 32'd0);
        chk(tag, {16'b0, busrdata}, {16'b0, exp});
        tick();
        chk({tag, "_ack_drop"}, {31'b0, busack}, 32'd0);
    endtask

    initial begin
        int k, m, lows;
        repeat (3) tick();
        chk("rst_busack", {31'b0, busack}, 32'd0);
        chk("rst_memreq", {31'b0, memreq}, 32'd0);
        chk("rst_regack", {31'b0, regack}, 32'd0);
        chk("rst_pins", {25'b0, j11irq, j11init, j11halt, j11parity},
            {25'b0, 4'hF, 1'b0, 1'b1, 1'b1});
        chk("rst_pins2", {29'b0, j11event, j11pwrf, j11fpe}, 32'd7);
        rstn = 1'b1;
        tick();
        rd(2'd0, 32'h00000F3E, "ctrl_rst");
        rd(2'd1, 32'h00000005, "pwrup_rst");

        gp(1'b1, 8'o0, 16'o000005, "gp_pwrup");
        wr(2'd1, 32'h0000FFFF);
        gp(1'b1, 8'o0, 16'o177777, "gp_pwrup_new");
        rd(2'd2, 32'h00000000, "status_gp0");
        gp(1'b0, 8'o17, 16'h0000, "gp_other");
        rd(2'd2, 32'h000F0000, "status_gp17");

        // memory read with 3-cycle ack delay
        m = n_mreq;
        busreq = 1'b1; buswr = 1'b0; busaddr = 22'o17777776;
        tick();
        busreq = 1'b0;
        chk("mrd_req", {31'b0, memreq}, 32'd1);
        chk("mrd_addr", {10'b0, memaddr}, {10'b0, 22'o17777776});
        chk("mrd_wr", {31'b0, memwr}, 32'd0);
        tick();
        chk("mrd_req_drop", {31'b0, memreq}, 32'd0);
        tick(); tick();
        chk("mrd_no_early_ack", {31'b0, busack}, 32'd0);
        chk("mrd_addr_held", {10'b0, memaddr}, {10'b0, 22'o17777776});
        memack = 1'b1; memrdata = 16'h1234;
        tick();
        memack = 1'b0;
        chk("mrd_ack", {31'b0, busack}, 32'd1);
        chk("mrd_data", {16'b0, busrdata}, 32'h1234);
        chk("mrd_err", {31'b0, buserr}, 32'd0);
        chk("mrd_one_req", n_mreq - m, 32'd1);
        tick();

        // memory write, immediate ack
        busreq = 1'b1; buswr = 1'b1; busaddr = 22'o123; buswdata = 16'hABCD;
        tick();
        busreq = 1'b0;
        chk("mwr_wr", {31'b0, memwr}, 32'd1);
        chk("mwr_data", {16'b0, memwdata}, 32'hABCD);
        memack = 1'b1;
        tick();
        memack = 1'b0;
        chk("mwr_ack", {31'b0, busack}, 32'd1);
        tick();

        // timeout
        busreq = 1'b1; buswr = 1'b0; busaddr = 22'o1000;
        tick();
        busreq = 1'b0;
        k = 0;
        do begin tick(); k++; end while (!busack && k < 100);
        chk("to_latency", k, 32'd16);
        chk("to_err", {31'b0, buserr}, 32'd1);
        chk("to_data", {16'b0, busrdata}, 32'd0);
        tick();
        rd(2'd2, 32'h000F0001, "status_to");
        memack = 1'b1;
        tick();
        memack = 1'b0;
        m = 0;
        repeat (3) begin tick(); if (busack) m++; end
        chk("late_ack_ignored", m, 32'd0);
        wr(2'd3, 32'd1);
        rd(2'd2, 32'h000F0000, "status_clr");

        // overrun during MEMWAIT, then reset mid-transaction
        m = n_mreq;
        busreq = 1'b1; buswr = 1'b0; busaddr = 22'o2000;
        tick();
        tick();
        busreq = 1'b0;
        rd(2'd2, 32'h030F0000, "status_ovr");
        chk("ovr_one_req", n_mreq - m, 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        m = 0;
        repeat (20) begin tick(); if (busack) m++; end
        chk("rst_mid_no_ack", m, 32'd0);
        rd(2'd2, 32'h00000000, "status_after_rst");

        // control pins
        wr(2'd0, 32'h000003A5);
        tick();
        chk("ctrl_pins", {24'b0, j11irq, j11init, j11halt, j11parity, j11event},
            {24'b0, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0});
        chk("ctrl_pins2", {30'b0, j11pwrf, j11fpe}, 32'd1);
        rd(2'd0, 32'h00000325, "ctrl_rb");
`ifdef J11BUS_LTC_EN
        wr(2'd0, 32'h00001008);
        lows = 0;
        repeat (40) begin tick(); if (!j11event) lows++; end
        chk("ltc_pulses", lows, 32'd4);
        rd(2'd2, 32'h04000000, "status_ltc");
        wr(2'd0, 32'h00000008);
        lows = 0;
        repeat (30) begin tick(); if (!j11event) lows++; end
        chk("ltc_stopped", lows, 32'd0);
`else
        wr(2'd0, 32'h00001008);
        lows = 0;
        repeat (30) begin tick(); if (!j11event) lows++; end
        chk("no_ltc", lows, 32'd0);
        rd(2'd0, 32'h00000008, "ctrl12_ro");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
